// File: rtl/booth_ctrl.sv
// booth_ctrl: sequencing controller and register file for a radix-2 Booth
// multiplier. Owns the AC / Q / q-1 / multiplicand registers, drives the
// downstream combinational ALU each iteration and writes its result back.
//
// Ports
//   clk, rst          rising-edge clock, asynchronous active-high reset
//   start             operation request, sampled only in IDLE
//   multiplicand      signed M, captured on the accepting edge
//   multiplier        signed multiplier, captured into Q on the accepting edge
//   busy              high from the cycle after acceptance through DONE
//   done              one-cycle pulse, product valid
//   product           signed 2W-bit {AC,Q}, held until replaced
//   range_err         valid with done: M was -2^(W-1)
//   alu_func/alu_en   ALU function select / enable (00 sub, 01 add, 10 ashr)
//   alu_ac/q/qm1/mcand register contents presented to the ALU
//   alu_valid         ALU result valid
//   alu_out           ALU result (add/sub in [2W:W+1], shift uses full word)
//   alu_err           (BOOTH_ALU_CHECK_EN only) one-cycle abort pulse
//
// Optional feature macro: BOOTH_ALU_CHECK_EN -- abort on alu_en && !alu_valid.
module booth_ctrl #(
  parameter int data_Width = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  input  logic [data_Width-1:0]   multiplicand,
  input  logic [data_Width-1:0]   multiplier,
  output logic                    busy,
  output logic                    done,
  output logic [2*data_Width-1:0] product,
  output logic                    range_err,
  output logic [1:0]              alu_func,
  output logic                    alu_en,
  output logic [data_Width-1:0]   alu_ac,
  output logic [data_Width-1:0]   alu_q,
  output logic                    alu_qm1,
  output logic [data_Width-1:0]   alu_mcand,
  input  logic                    alu_valid,
  input  logic [2*data_Width:0]   alu_out
`ifdef BOOTH_ALU_CHECK_EN
  ,
  output logic                    alu_err
`endif
);

  localparam int W  = data_Width;
  localparam int CW = $clog2(W + 1);

  localparam logic [1:0] FN_SUB = 2'b00;
  localparam logic [1:0] FN_ADD = 2'b01;
  localparam logic [1:0] FN_SHR = 2'b10;

  typedef enum logic [1:0] {IDLE, ARITH, SHIFT, DONE} state_t;

  state_t           state_q, state_d;
  logic [W-1:0]     ac_q, ac_d;
  logic [W-1:0]     qr_q, qr_d;
  logic             qm1_q, qm1_d;
  logic [W-1:0]     m_q, m_d;
  logic [CW-1:0]    count_q, count_d;
  logic [2*W-1:0]   product_q, product_d;
  logic             rerr_q, rerr_d;

  // Most negative W-bit value: its negation is not representable in AC.
  logic [W-1:0] m_min;
  assign m_min = {1'b1, {(W-1){1'b0}}};

`ifdef BOOTH_ALU_CHECK_EN
  logic alu_err_q, alu_err_d;
  logic abort;
`else
  logic unused_alu_valid;
  assign unused_alu_valid = alu_valid;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      ac_q      <= '0;
      qr_q      <= '0;
      qm1_q     <= 1'b0;
      m_q       <= '0;
      count_q   <= '0;
      product_q <= '0;
      rerr_q    <= 1'b0;
`ifdef BOOTH_ALU_CHECK_EN
      alu_err_q <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      ac_q      <= ac_d;
      qr_q      <= qr_d;
      qm1_q     <= qm1_d;
      m_q       <= m_d;
      count_q   <= count_d;
      product_q <= product_d;
      rerr_q    <= rerr_d;
`ifdef BOOTH_ALU_CHECK_EN
      alu_err_q <= alu_err_d;
`endif
    end
  end

  always_comb begin
    state_d   = state_q;
    ac_d      = ac_q;
    qr_d      = qr_q;
    qm1_d     = qm1_q;
    m_d       = m_q;
    count_d   = count_q;
    product_d = product_q;
    rerr_d    = rerr_q;
    alu_func  = FN_SHR;
    alu_en    = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (start) begin
          ac_d    = '0;
          qr_d    = multiplier;
          qm1_d   = 1'b0;
          m_d     = multiplicand;
          count_d = CW'(W);
          rerr_d  = (multiplicand == m_min);
          state_d = ARITH;
        end
      end
      ARITH: begin
        // 00/11 is an idle slot so every iteration takes two cycles.
        unique case ({qr_q[0], qm1_q})
          2'b10: begin
            alu_func = FN_SUB;
            alu_en   = 1'b1;
            ac_d     = alu_out[2*W:W+1];
          end
          2'b01: begin
            alu_func = FN_ADD;
            alu_en   = 1'b1;
            ac_d     = alu_out[2*W:W+1];
          end
          default: ;
        endcase
        state_d = SHIFT;
      end
      SHIFT: begin
        alu_func = FN_SHR;
        alu_en   = 1'b1;
        {ac_d, qr_d, qm1_d} = alu_out;
        count_d  = count_q - CW'(1);
        if (count_q == CW'(1)) begin
          // Capture the post-shift {AC,Q} so product is valid on DONE entry.
          product_d = alu_out[2*W:1];
          state_d   = DONE;
        end else begin
          state_d = ARITH;
        end
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase

`ifdef BOOTH_ALU_CHECK_EN
    abort     = alu_en & ~alu_valid;
    alu_err_d = abort;
    if (abort) begin
      state_d   = IDLE;
      ac_d      = ac_q;
      qr_d      = qr_q;
      qm1_d     = qm1_q;
      m_d       = m_q;
      count_d   = count_q;
      product_d = product_q;
      rerr_d    = rerr_q;
    end
`endif
  end

  assign busy      = (state_q != IDLE);
  assign done      = (state_q == DONE);
  assign range_err = done & rerr_q;
  assign product   = product_q;
  assign alu_ac    = ac_q;
  assign alu_q     = qr_q;
  assign alu_qm1   = qm1_q;
  assign alu_mcand = m_q;
`ifdef BOOTH_ALU_CHECK_EN
  assign alu_err   = alu_err_q;
`endif

endmodule
